// File: rtl/regfile_8x16.sv
// rtl/regfile_8x16.sv - eight-entry register file, one write port, two combinational read ports
//
// Ports:
//   clk          clock, all state updates on rising edge
//   rst_n        asynchronous active-low reset, clears all registers and err
//   read1RegSel  register index for read port 1
//   read2RegSel  register index for read port 2
//   writeRegSel  register index for the write port
//   writeData    data to be written
//   write        write enable
//   read1Data    read port 1 data (stored word or same-cycle write data)
//   read2Data    read port 2 data (stored word or same-cycle write data)
//   err          sticky flag: a write was attempted with X/Z on index or data

module regfile_8x16 #(
    parameter int WIDTH  = 16,
    parameter bit BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       read1RegSel,
    input  logic [2:0]       read2RegSel,
    input  logic [2:0]       writeRegSel,
    input  logic [WIDTH-1:0] writeData,
    input  logic             write,
    output logic [WIDTH-1:0] read1Data,
    output logic [WIDTH-1:0] read2Data,
    output logic             err
);

    logic [WIDTH-1:0] regs [8];
    logic [7:0]       wr_onehot;

    // Both read ports are handled identically; pack their selects for the loop.
    logic [2:0]       rd_sel    [2];
    logic [WIDTH-1:0] lvl1      [2][4];
    logic [WIDTH-1:0] lvl2      [2][2];
    logic [WIDTH-1:0] stored    [2];
    logic             hit       [2];
    logic [WIDTH-1:0] rd_data   [2];

    assign wr_onehot = write ? (8'd1 << writeRegSel) : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (wr_onehot[i]) begin
                    regs[i] <= writeData;
                end
            end
        end
    end

    // Simulation aid: on 2-state simulators and in synthesis this never fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (write && $isunknown({writeRegSel, writeData})) begin
            err <= 1'b1;
        end
    end

    assign rd_sel[0] = read1RegSel;
    assign rd_sel[1] = read2RegSel;

    // Binary select tree: index bit 0 picks within pairs, bit 1 within quads,
    // bit 2 between halves.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) begin
                lvl1[p][i] = rd_sel[p][0] ? regs[2*i+1] : regs[2*i];
            end
            for (int i = 0; i < 2; i++) begin
                lvl2[p][i] = rd_sel[p][1] ? lvl1[p][2*i+1] : lvl1[p][2*i];
            end
            stored[p] = rd_sel[p][2] ? lvl2[p][1] : lvl2[p][0];
        end
    end

    // Forwarding is gated by rst_n so reads stay at zero throughout reset.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            hit[p]     = BYPASS && rst_n && write && (rd_sel[p] == writeRegSel);
            rd_data[p] = hit[p] ? writeData : stored[p];
        end
    end

    assign read1Data = rd_data[0];
    assign read2Data = rd_data[1];

endmodule

// File: tb/tb_regfile_8x16.sv
// tb/tb_regfile_8x16.sv - scoreboard bench for regfile_8x16 (bypass and no-bypass instances)

module tb_regfile_8x16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  read1RegSel, read2RegSel, writeRegSel;
    logic [15:0] writeData;
    logic        write;
    logic [15:0] bp_r1, bp_r2, nb_r1, nb_r2;
    logic        bp_err, nb_err;

    always #5 clk = ~clk;

    regfile_8x16 #(.WIDTH(16), .BYPASS(1'b1)) u_bp (
        .clk(clk), .rst_n(rst_n),
        .read1RegSel(read1RegSel), .read2RegSel(read2RegSel),
        .writeRegSel(writeRegSel), .writeData(writeData), .write(write),
        .read1Data(bp_r1), .read2Data(bp_r2), .err(bp_err)
    );

    regfile_8x16 #(.WIDTH(16), .BYPASS(1'b0)) u_nb (
        .clk(clk), .rst_n(rst_n),
        .read1RegSel(read1RegSel), .read2RegSel(read2RegSel),
        .writeRegSel(writeRegSel), .writeData(writeData), .write(write),
        .read1Data(nb_r1), .read2Data(nb_r2), .err(nb_err)
    );

    typedef struct {
        logic [15:0] bp1, bp2, nb1, nb2;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] mem [8];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, so each cycle presents one result mid-period.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.tag, " bp read1"}, bp_r1, e.bp1);
            check({e.tag, " bp read2"}, bp_r2, e.bp2);
            check({e.tag, " nb read1"}, nb_r1, e.nb1);
            check({e.tag, " nb read2"}, nb_r2, e.nb2);
            check({e.tag, " bp err"}, {15'd0, bp_err}, 16'd0);
            check({e.tag, " nb err"}, {15'd0, nb_err}, 16'd0);
        end
    end

    // One cycle: retire the write the previous cycle presented at this edge,
    // then drive new inputs and push the expected read results.
    task automatic cycle(input logic rst, input logic we, input logic [2:0] ws,
                         input logic [15:0] wd, input logic [2:0] s1, input logic [2:0] s2,
                         input string tag);
        exp_t e;
        @(posedge clk);
        if (rst_n && write) mem[writeRegSel] = writeData;
        #1;
        rst_n = rst; write = we; writeRegSel = ws; writeData = wd;
        read1RegSel = s1; read2RegSel = s2;
        if (!rst) for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
        e.nb1 = mem[s1];
        e.nb2 = mem[s2];
        e.bp1 = (rst && we && s1 == ws) ? wd : mem[s1];
        e.bp2 = (rst && we && s2 == ws) ? wd : mem[s2];
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0; write = 1'b0; writeRegSel = 3'd0; writeData = 16'h0;
        read1RegSel = 3'd0; read2RegSel = 3'd0;
        for (int i = 0; i < 8; i++) mem[i] = 16'h0000;

        // Reset held with write asserted: nothing may be captured or forwarded.
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < 8; i += 2)
                cycle(1'b0, 1'b1, 3'(i), 16'hFFFF, 3'(i), 3'(i + 1), "reset");
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 1'b0, 3'd0, 16'hFFFF, 3'(i), 3'(7 - i), "post_reset");

        // Fill with distinct values, then sweep both ports.
        for (int k = 0; k < 8; k++)
            cycle(1'b1, 1'b1, 3'(k), 16'(16'h1111 * k + 16'h0F0F), 3'(k), 3'((k + 5) % 8), "fill");
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i), "sweep");

        // Same-cycle read of the register being written.
        cycle(1'b1, 1'b1, 3'd3, 16'h1234, 3'd0, 3'd1, "bp_setup");
        cycle(1'b1, 1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd4, "bp_hit");
        cycle(1'b1, 1'b0, 3'd3, 16'h0000, 3'd3, 3'd3, "bp_after");
        cycle(1'b1, 1'b1, 3'd6, 16'hC0DE, 3'd6, 3'd6, "bp_both");

        // Write disabled must not disturb the addressed register.
        for (int c = 0; c < 4; c++)
            cycle(1'b1, 1'b0, 3'd2, 16'hAAAA, 3'd2, 3'd2, "wr_off");

        // Asynchronous reset mid-cycle while a write is pending.
        cycle(1'b1, 1'b1, 3'd7, 16'h5A5A, 3'd0, 3'd1, "r7_set");
        cycle(1'b1, 1'b0, 3'd7, 16'h0000, 3'd7, 3'd7, "r7_chk");
        cycle(1'b0, 1'b1, 3'd7, 16'hFFFF, 3'd7, 3'd7, "async_rst");
        cycle(1'b1, 1'b1, 3'd7, 16'h0001, 3'd0, 3'd6, "rel_wr");
        cycle(1'b1, 1'b0, 3'd7, 16'h0000, 3'd7, 3'd7, "rel_chk");

        // Randomized traffic, including back-to-back writes to one register.
        for (int c = 0; c < 300; c++)
            cycle(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  16'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), "random");

        @(posedge clk);
        @(posedge clk);
        check("scoreboard drained", 16'(sb_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
